// File: rtl/safe_entry_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : safe_entry_ctrl
// Brief    : Safe keypad front-end. Conditions the confirm button, sequences
//            digit entry and verdicts, and enforces a timed lockout after
//            repeated failed attempts. Optional macro PENALTY_DOUBLE_EN makes
//            each repeated lockout double in length (up to 8x the base time).
// Revision : 1.0 - initial release
// ============================================================================
module safe_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 250000000,
    parameter int LOCK_CYCLES     = 150000000,
    parameter int MAX_FAILS       = 3,
    parameter int CNT_W           = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_confirm_raw,
    input  logic       i_verdict_valid,
    input  logic       i_verdict_ok,
    output logic       o_confirm_pulse,
    output logic       o_confirm_drop,
    output logic       o_abort_pulse,
    output logic [2:0] o_entry_count,
    output logic [2:0] o_fail_count,
    output logic       o_lockout,
    output logic [1:0] o_ctrl_state
);

    localparam int               c_DB_W         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST     = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_LOCK_BASE    = CNT_W'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE          = CNT_W'(1);
    localparam logic [2:0]       c_MAX_FAILS    = 3'(MAX_FAILS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ENTRY = 2'b01,
        ST_WAIT  = 2'b10,
        ST_LOCK  = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: two-flop synchroniser followed by debounce
    // ------------------------------------------------------------------
    logic              r_sync1;
    logic              r_sync2;
    logic              r_deb;
    logic              r_deb_q;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              w_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_deb    <= 1'b0;
            r_deb_q  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= i_confirm_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            if (r_sync2 == r_deb) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_deb    <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_press = r_deb & ~r_deb_q;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [2:0]       r_entry;
    logic [2:0]       w_entry_nxt;
    logic [2:0]       r_fail;
    logic [2:0]       w_fail_nxt;
    logic [2:0]       w_fail_inc;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic             r_drop;
    logic             w_drop_nxt;
    logic             r_abort;
    logic             w_abort_nxt;
    logic [CNT_W-1:0] w_lock_load;

`ifdef PENALTY_DOUBLE_EN
    logic [1:0] r_lock_shift;
    logic [1:0] w_shift_nxt;

    assign w_lock_load = c_LOCK_BASE << r_lock_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_shift <= 2'd0;
        end else begin
            r_lock_shift <= w_shift_nxt;
        end
    end
`else
    assign w_lock_load = c_LOCK_BASE;
`endif

    assign w_fail_inc = (r_fail >= c_MAX_FAILS) ? c_MAX_FAILS : r_fail + 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_entry_nxt = r_entry;
        w_fail_nxt  = r_fail;
        w_pulse_nxt = 1'b0;
        w_drop_nxt  = 1'b0;
        w_abort_nxt = 1'b0;
`ifdef PENALTY_DOUBLE_EN
        w_shift_nxt = r_lock_shift;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_pulse_nxt = 1'b1;
                    w_entry_nxt = 3'd1;
                    w_timer_nxt = c_TIMEOUT_LOAD;
                    w_state_nxt = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                // An accepted press outranks a timeout expiring in the same cycle
                if (w_press) begin
                    w_pulse_nxt = 1'b1;
                    w_entry_nxt = r_entry + 3'd1;
                    w_timer_nxt = c_TIMEOUT_LOAD;
                    if (r_entry == 3'd3) begin
                        w_state_nxt = ST_WAIT;
                    end
                end else if (r_timer == '0) begin
                    w_abort_nxt = 1'b1;
                    w_entry_nxt = 3'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - c_ONE;
                end
            end
            ST_WAIT: begin
                w_drop_nxt = w_press;
                if (i_verdict_valid) begin
                    if (i_verdict_ok) begin
                        w_fail_nxt  = 3'd0;
                        w_entry_nxt = 3'd0;
                        w_state_nxt = ST_IDLE;
`ifdef PENALTY_DOUBLE_EN
                        w_shift_nxt = 2'd0;
`endif
                    end else begin
                        w_fail_nxt = w_fail_inc;
                        if (w_fail_inc == c_MAX_FAILS) begin
                            w_timer_nxt = w_lock_load - c_ONE;
                            w_state_nxt = ST_LOCK;
                        end else begin
                            w_entry_nxt = 3'd0;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end else if (r_timer == '0) begin
                    w_abort_nxt = 1'b1;
                    w_entry_nxt = 3'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - c_ONE;
                end
            end
            default: begin
                w_drop_nxt = w_press;
                if (r_timer == '0) begin
                    w_fail_nxt  = 3'd0;
                    w_entry_nxt = 3'd0;
                    w_state_nxt = ST_IDLE;
`ifdef PENALTY_DOUBLE_EN
                    w_shift_nxt = (r_lock_shift == 2'd3) ? 2'd3 : r_lock_shift + 2'd1;
`endif
                end else begin
                    w_timer_nxt = r_timer - c_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_entry <= 3'd0;
            r_fail  <= 3'd0;
            r_pulse <= 1'b0;
            r_drop  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_entry <= w_entry_nxt;
            r_fail  <= w_fail_nxt;
            r_pulse <= w_pulse_nxt;
            r_drop  <= w_drop_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    assign o_confirm_pulse = r_pulse;
    assign o_confirm_drop  = r_drop;
    assign o_abort_pulse   = r_abort;
    assign o_entry_count   = r_entry;
    assign o_fail_count    = r_fail;
    assign o_lockout       = (r_state == ST_LOCK);
    assign o_ctrl_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_safe_entry_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_safe_entry_ctrl
// Brief    : Self-checking bench for safe_entry_ctrl with an attempt-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_safe_entry_ctrl;

    localparam int DEB  = 4;
    localparam int TO   = 50;
    localparam int LOCK = 20;
    localparam int MAXF = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       raw   = 1'b0;
    logic       vv    = 1'b0;
    logic       vok   = 1'b0;
    logic       o_confirm_pulse;
    logic       o_confirm_drop;
    logic       o_abort_pulse;
    logic [2:0] o_entry_count;
    logic [2:0] o_fail_count;
    logic       o_lockout;
    logic [1:0] o_ctrl_state;

    safe_entry_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO),
        .LOCK_CYCLES    (LOCK),
        .MAX_FAILS      (MAXF),
        .CNT_W          (31)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_confirm_raw  (raw),
        .i_verdict_valid(vv),
        .i_verdict_ok   (vok),
        .o_confirm_pulse(o_confirm_pulse),
        .o_confirm_drop (o_confirm_drop),
        .o_abort_pulse  (o_abort_pulse),
        .o_entry_count  (o_entry_count),
        .o_fail_count   (o_fail_count),
        .o_lockout      (o_lockout),
        .o_ctrl_state   (o_ctrl_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_pulse = 0, n_drop = 0, n_abort = 0;
    int last_pulse = -1, last_drop = -1, last_abort = -1;
    int lock_rise = -1, lock_fall = -1;
    logic prev_lock = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: every strobe and lockout edge tagged with its cycle number
    always @(negedge clk) begin
        if (o_confirm_pulse === 1'b1) begin n_pulse++; last_pulse = cyc; end
        if (o_confirm_drop  === 1'b1) begin n_drop++;  last_drop  = cyc; end
        if (o_abort_pulse   === 1'b1) begin n_abort++; last_abort = cyc; end
        if (o_lockout === 1'b1 && prev_lock === 1'b0) lock_rise = cyc;
        if (o_lockout === 1'b0 && prev_lock === 1'b1) lock_fall = cyc;
        prev_lock = o_lockout;
    end

    // Attempt-level reference model: 0 idle, 1 entering, 2 awaiting verdict, 3 locked
    int m_state = 0, m_entries = 0, m_fails = 0, m_shift = 0, m_lock_len = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".state"}, 32'(o_ctrl_state), 32'(m_state));
        check({tag, ".fails"}, 32'(o_fail_count), 32'(m_fails));
        check({tag, ".lockout"}, 32'(o_lockout), (m_state == 3) ? 32'd1 : 32'd0);
        if (m_state != 3) check({tag, ".entries"}, 32'(o_entry_count), 32'(m_entries));
    endtask

    task automatic press(input int hold, input bit bounce);
        int c0, p0, d0;
        bit acc;
        acc = (m_state == 0 || m_state == 1);
        p0  = n_pulse;
        d0  = n_drop;
        if (bounce) begin
            repeat (3) begin
                raw = 1'b1; step(); step();
                raw = 1'b0; step();
            end
        end
        c0  = cyc;
        raw = 1'b1;
        repeat (hold) step();
        raw = 1'b0;
        repeat (DEB + 4) step();
        if (acc) begin
            check("press.pulses", n_pulse - p0, 1);
            check("press.latency", last_pulse - c0, 7);
            check("press.drops", n_drop - d0, 0);
            m_entries++;
            m_state = (m_entries == 4) ? 2 : 1;
        end else begin
            check("drop.drops", n_drop - d0, 1);
            check("drop.latency", last_drop - c0, 7);
            check("drop.pulses", n_pulse - p0, 0);
        end
        check_model("press");
    endtask

    task automatic verdict(input bit ok);
        vv  = 1'b1;
        vok = ok;
        step();
        vv  = 1'b0;
        vok = 1'b0;
        if (m_state == 2) begin
            if (ok) begin
                m_fails = 0; m_shift = 0; m_state = 0; m_entries = 0;
            end else begin
                m_fails = (m_fails < MAXF) ? m_fails + 1 : MAXF;
                if (m_fails == MAXF) begin
                    m_state = 3;
`ifdef PENALTY_DOUBLE_EN
                    m_lock_len = LOCK << m_shift;
`else
                    m_lock_len = LOCK;
`endif
                end else begin
                    m_state = 0; m_entries = 0;
                end
            end
        end
        check_model("verdict");
    endtask

    task automatic wait_lock_end();
        int n;
        n = 0;
        while (o_lockout === 1'b1 && n < 1000) begin
            step();
            n++;
        end
        step();
        check("lock.bounded", (n < 1000) ? 32'd1 : 32'd0, 32'd1);
        check("lock.length", lock_fall - lock_rise, m_lock_len);
        m_state = 0; m_fails = 0; m_entries = 0;
        m_shift = (m_shift < 3) ? m_shift + 1 : 3;
        check_model("lockexit");
    endtask

    task automatic attempt(input bit ok, input bit lock_press, input bit lock_wait);
        repeat (4) press($urandom_range(12, 8), 1'b0);
        repeat ($urandom_range(10, 0)) step();
        verdict(ok);
        if (m_state == 3) begin
            if (lock_press) press(8, 1'b0);
            if (lock_wait) wait_lock_end();
        end
    endtask

    task automatic timeout_check(input int presses);
        int a0, p_last;
        repeat (presses) press($urandom_range(12, 8), 1'b0);
        a0     = n_abort;
        p_last = last_pulse;
        repeat (TO + 10) step();
        check("timeout.aborts", n_abort - a0, 1);
        check("timeout.delay", last_abort - p_last, TO);
        m_state = 0; m_entries = 0;
        check_model("timeout");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        repeat (3) step();
        check("reset.pulse", 32'(o_confirm_pulse), 0);
        check("reset.drop", 32'(o_confirm_drop), 0);
        check("reset.abort", 32'(o_abort_pulse), 0);
        check_model("reset");
        rst_n = 1'b1;
        step();

        press(10, 1'b0);                     // clean press
        press(10, 1'b1);                     // bounced press
        press($urandom_range(12, 8), 1'b0);
        press($urandom_range(12, 8), 1'b0);
        verdict(1'b1);                       // correct code
        verdict(1'b0);                       // stray verdict in IDLE

        attempt(1'b0, 1'b0, 1'b0);           // one fail before timeout test
        timeout_check(2);
        attempt(1'b0, 1'b0, 1'b0);
        attempt(1'b0, 1'b1, 1'b1);           // third fail: lockout with a dropped press

        for (int i = 0; i < 8; i++) begin
            attempt(($urandom_range(2, 0) == 0), $urandom_range(1, 0) == 1, 1'b1);
        end

        timeout_check(4);                    // timeout while awaiting verdict

        guard = 0;
        while (m_state != 3 && guard < MAXF + 1) begin
            attempt(1'b0, 1'b0, 1'b0);
            guard++;
        end
        repeat ($urandom_range(10, 2)) step();
        rst_n = 1'b0;
        #1;
        m_state = 0; m_entries = 0; m_fails = 0; m_shift = 0;
        check_model("async_reset");
        step();
        rst_n = 1'b1;
        step();
        press($urandom_range(12, 8), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
